// File: rtl/dmem_pkg.sv
// Shared encodings for the wait-stated data memory: access sizes, FSM states
// and the default base address of word 0.
package dmem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam logic [31:0] DMEM_BASE_ADDR = 32'h1001_0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } dmem_state_e;

endpackage

// File: rtl/dmem_aligner.sv
// Combinational lane logic: fault detection, store byte-enables and lane
// replication, and load extraction with sign/zero extension.
module dmem_aligner
  import dmem_pkg::*;
#(
  parameter int unsigned MEMORY_DEPTH = 256
) (
  input  logic [31:0] offset_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic        err_o,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  localparam logic [32:0] LIMIT = 33'(4 * MEMORY_DEPTH);

  logic [1:0]  lane;
  logic [31:0] rsh;

  always_comb begin
    lane    = offset_i[1:0];
    rsh     = rword_i >> {lane, 3'b000};
    err_o   = 1'b0;
    be_o    = '0;
    wdata_o = '0;
    rdata_o = '0;

    // Addresses below the base wrap to huge offsets and fail this check too.
    if ({1'b0, offset_i} >= LIMIT) err_o = 1'b1;

    case (size_i)
      SIZE_BYTE: begin
        be_o    = 4'b0001 << lane;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = unsigned_i ? {24'h0, rsh[7:0]} : {{24{rsh[7]}}, rsh[7:0]};
      end
      SIZE_HALF: begin
        if (offset_i[0]) err_o = 1'b1;
        be_o    = offset_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = unsigned_i ? {16'h0, rsh[15:0]} : {{16{rsh[15]}}, rsh[15:0]};
      end
      SIZE_WORD: begin
        if (lane != 2'b00) err_o = 1'b1;
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        rdata_o = rword_i;
      end
      default: err_o = 1'b1;
    endcase

    if (err_o) be_o = '0;
  end

endmodule

// File: rtl/data_memory_ws.sv
// Wait-stated data memory with req/ready handshake and byte/half/word access.
// Define DMEM_FAST_READ_EN to let loads skip the wait states.
module data_memory_ws
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned MEMORY_DEPTH = 256,
  parameter logic [31:0] BASE_ADDR    = DMEM_BASE_ADDR,
  parameter int unsigned WAIT_STATES  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [1:0]            size_i,
  input  logic                  unsigned_i,
  input  logic [31:0]           address_i,
  input  logic [DATA_WIDTH-1:0] write_data_i,
  output logic                  ready_o,
  output logic                  error_o,
  output logic [DATA_WIDTH-1:0] read_data_o
);

  localparam int unsigned IDX_W = $clog2(MEMORY_DEPTH);
  localparam logic [2:0]  WS3   = 3'(WAIT_STATES);

  dmem_state_e     state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [1:0]      size_q, size_d;
  logic            uns_q, uns_d;
  logic [31:0]     off_q, off_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            err_q, err_d;
  logic            ready_q, ready_d;
  logic            error_q, error_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic [31:0] mem_q [MEMORY_DEPTH];

  logic [31:0]      in_off, al_off, al_wdata_in, al_rword, al_wdata, al_rdata;
  logic [1:0]       al_size;
  logic             al_uns, al_err, mem_we;
  logic [3:0]       al_be;
  logic [IDX_W-1:0] idx;

  assign in_off = address_i - BASE_ADDR;

  // One aligner serves both phases: live inputs while idle, latched request after.
  always_comb begin
    if (state_q == ST_IDLE) begin
      al_off      = in_off;
      al_size     = size_i;
      al_uns      = unsigned_i;
      al_wdata_in = write_data_i;
    end else begin
      al_off      = off_q;
      al_size     = size_q;
      al_uns      = uns_q;
      al_wdata_in = wdata_q;
    end
    idx      = al_off[IDX_W+1:2];
    al_rword = mem_q[idx];
  end

  dmem_aligner #(
    .MEMORY_DEPTH(MEMORY_DEPTH)
  ) u_aligner (
    .offset_i  (al_off),
    .size_i    (al_size),
    .unsigned_i(al_uns),
    .wdata_i   (al_wdata_in),
    .rword_i   (al_rword),
    .err_o     (al_err),
    .be_o      (al_be),
    .wdata_o   (al_wdata),
    .rdata_o   (al_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    off_d   = off_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    ready_d = 1'b0;
    error_d = 1'b0;
    mem_we  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_i) begin
          we_d    = we_i;
          size_d  = size_i;
          uns_d   = unsigned_i;
          off_d   = in_off;
          wdata_d = write_data_i;
          err_d   = al_err;
`ifdef DMEM_FAST_READ_EN
          cnt_d   = we_i ? WS3 : '0;
`else
          cnt_d   = WS3;
`endif
          state_d = al_err ? ST_DONE : ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 3'd1;
        end else begin
          mem_we  = we_q;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        ready_d = 1'b1;
        error_d = err_q;
        if (!we_q) rdata_d = err_q ? '0 : al_rdata;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      off_q   <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
      error_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      off_q   <= off_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      ready_q <= ready_d;
      error_q <= error_d;
      rdata_q <= rdata_d;
    end
  end

  // RAM is never cleared; a reset before the commit edge leaves state_q idle.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned l = 0; l < 4; l++) begin
        if (al_be[l]) mem_q[idx][8*l +: 8] <= al_wdata[8*l +: 8];
      end
    end
  end

  assign ready_o     = ready_q;
  assign error_o     = error_q;
  assign read_data_o = rdata_q;

endmodule

// File: tb/tb_data_memory_ws.sv
// Self-checking bench for data_memory_ws: directed vector table, handshake and
// reset-abort sequences, then random accesses against a byte-array model.
module tb_data_memory_ws;

  localparam int unsigned DEPTH = 256;
  localparam logic [31:0] BASE  = 32'h1001_0000;
  localparam int unsigned WS    = 1;
`ifdef DMEM_FAST_READ_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req_i, we_i, unsigned_i;
  logic [1:0]  size_i;
  logic [31:0] address_i, write_data_i;
  logic        ready_o, error_o;
  logic [31:0] read_data_o;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mem_m [4*DEPTH];
  logic [31:0] last_rd_m = '0;

  always #5 clk = ~clk;

  data_memory_ws #(
    .DATA_WIDTH  (32),
    .MEMORY_DEPTH(DEPTH),
    .BASE_ADDR   (BASE),
    .WAIT_STATES (WS)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_i       (req_i),
    .we_i        (we_i),
    .size_i      (size_i),
    .unsigned_i  (unsigned_i),
    .address_i   (address_i),
    .write_data_i(write_data_i),
    .ready_o     (ready_o),
    .error_o     (error_o),
    .read_data_o (read_data_o)
  );

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        exp_err;
    logic        chk_rd;
    logic [31:0] exp_rd;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic we, input logic err);
    if (err) return 1;
    if (FAST && !we) return 2;
    return WS + 2;
  endfunction

  // Reference: byte-addressed little-endian memory, faults from plain arithmetic.
  function automatic void model(input logic we, input logic [1:0] sz, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wd,
                                output logic [31:0] erd, output logic eerr);
    logic [31:0] off;
    logic [31:0] v;
    int n;
    off  = addr - BASE;
    n    = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 1;
    eerr = (off >= 32'(4 * DEPTH)) || (sz == 2'd3) || ((off % 32'(n)) != 0);
    if (eerr) begin
      if (!we) last_rd_m = '0;
    end else if (we) begin
      for (int b = 0; b < n; b++) mem_m[int'(off) + b] = wd[8*b +: 8];
    end else begin
      v = '0;
      for (int b = 0; b < n; b++) v = v | (32'(mem_m[int'(off) + b]) << (8 * b));
      if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
      last_rd_m = v;
    end
    erd = last_rd_m;
  endfunction

  task automatic access(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output logic err, output int lat);
    @(negedge clk);
    we_i = we; size_i = sz; unsigned_i = uns; address_i = addr; write_data_i = wd;
    req_i = 1'b1;
    lat = -1; rd = 'x; err = 1'bx;
    for (int e = 0; e < 64; e++) begin
      @(posedge clk);
      #1;
      if (e == 0) begin
        we_i = $urandom_range(0, 1); size_i = 2'($urandom_range(0, 3));
        unsigned_i = $urandom_range(0, 1);
        address_i = $urandom; write_data_i = $urandom;
      end
      if (ready_o) begin
        lat = e; rd = read_data_o; err = error_o;
        break;
      end
    end
    req_i = 1'b0;
  endtask

  task automatic run_checked(input string tag, input logic we, input logic [1:0] sz,
                             input logic uns, input logic [31:0] addr, input logic [31:0] wd);
    logic [31:0] rd, erd;
    logic err, eerr;
    int lat;
    model(we, sz, uns, addr, wd, erd, eerr);
    access(we, sz, uns, addr, wd, rd, err, lat);
    check({tag, "_err"}, 32'(err), 32'(eerr));
    check({tag, "_lat"}, lat, exp_lat(we, eerr));
    check({tag, "_rd"}, rd, erd);
  endtask

  initial begin
    vec_t vecs[$];
    logic [31:0] rd, erd;
    logic err, eerr;
    int lat, pulses, prev, L, S;

    reset = 1'b1; req_i = 1'b0; we_i = 1'b0; size_i = '0; unsigned_i = 1'b0;
    address_i = '0; write_data_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(ready_o), 32'h0);
    check("rst_error", 32'(error_o), 32'h0);
    check("rst_rdata", read_data_o, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < int'(DEPTH); i++) begin
      logic [31:0] w;
      w = $urandom;
      model(1'b1, 2'd2, 1'b0, BASE + 32'(4 * i), w, erd, eerr);
      access(1'b1, 2'd2, 1'b0, BASE + 32'(4 * i), w, rd, err, lat);
      if (i % 64 == 0) check("init_lat", lat, WS + 2);
    end

    //              we    sz     uns   addr           wd             err   chk   rd
    vecs.push_back('{1'b1, 2'd2, 1'b0, 32'h1001_0010, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 2'd2, 1'b1, 32'h1001_0010, 32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF});
    vecs.push_back('{1'b1, 2'd2, 1'b0, 32'h1001_0020, 32'h1122_3344, 1'b0, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 2'd0, 1'b0, 32'h1001_0021, 32'hFFFF_FF80, 1'b0, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h1001_0020, 32'h0,         1'b0, 1'b1, 32'h1122_8044});
    vecs.push_back('{1'b0, 2'd0, 1'b0, 32'h1001_0021, 32'h0,         1'b0, 1'b1, 32'hFFFF_FF80});
    vecs.push_back('{1'b0, 2'd0, 1'b1, 32'h1001_0021, 32'h0,         1'b0, 1'b1, 32'h0000_0080});
    vecs.push_back('{1'b0, 2'd1, 1'b0, 32'h1001_0022, 32'h0,         1'b0, 1'b1, 32'h0000_1122});
    vecs.push_back('{1'b0, 2'd1, 1'b0, 32'h1001_0020, 32'h0,         1'b0, 1'b1, 32'hFFFF_8044});
    vecs.push_back('{1'b1, 2'd1, 1'b0, 32'h1001_0022, 32'h5555_BEEF, 1'b0, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h1001_0020, 32'h0,         1'b0, 1'b1, 32'hBEEF_8044});
    vecs.push_back('{1'b0, 2'd1, 1'b1, 32'h1001_0022, 32'h0,         1'b0, 1'b1, 32'h0000_BEEF});
    vecs.push_back('{1'b0, 2'd1, 1'b0, 32'h1001_0001, 32'h0,         1'b1, 1'b1, 32'h0});
    vecs.push_back('{1'b1, 2'd2, 1'b0, 32'h1001_0002, 32'h1234_5678, 1'b1, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 2'd2, 1'b0, 32'h1001_0012, 32'h1234_5678, 1'b1, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h1001_0400, 32'h0,         1'b1, 1'b1, 32'h0});
    vecs.push_back('{1'b0, 2'd3, 1'b0, 32'h1001_0010, 32'h0,         1'b1, 1'b1, 32'h0});
    vecs.push_back('{1'b1, 2'd2, 1'b0, 32'h1000_FFFC, 32'hCAFE_F00D, 1'b1, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h1001_0010, 32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF});
    vecs.push_back('{1'b1, 2'd0, 1'b0, 32'h1001_03FF, 32'h0000_005A, 1'b0, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 2'd0, 1'b1, 32'h1001_03FF, 32'h0,         1'b0, 1'b1, 32'h0000_005A});

    for (int i = 0; i < vecs.size(); i++) begin
      model(vecs[i].we, vecs[i].sz, vecs[i].uns, vecs[i].addr, vecs[i].wd, erd, eerr);
      access(vecs[i].we, vecs[i].sz, vecs[i].uns, vecs[i].addr, vecs[i].wd, rd, err, lat);
      check($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d_lat", i), lat, exp_lat(vecs[i].we, vecs[i].exp_err));
      if (vecs[i].chk_rd) check($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
    end

    // Held request: back-to-back loads, no extra accept during the done cycle.
    L = exp_lat(1'b0, 1'b0);
    S = L + 1;
    pulses = 0; prev = -1;
    @(negedge clk);
    we_i = 1'b0; size_i = 2'd2; unsigned_i = 1'b0; address_i = 32'h1001_0010; req_i = 1'b1;
    for (int e = 0; e <= L + 2 * S; e++) begin
      @(posedge clk);
      #1;
      if (ready_o) begin
        model(1'b0, 2'd2, 1'b0, 32'h1001_0010, 32'h0, erd, eerr);
        check("hs_rd", read_data_o, erd);
        check("hs_err", 32'(error_o), 32'(eerr));
        if (pulses == 0) check("hs_first", e, L);
        else check("hs_space", e - prev, S);
        prev = e;
        pulses++;
      end
    end
    req_i = 1'b0;
    check("hs_count", pulses, 3);

    // Reset while the store waits in BUSY: no write happens.
    @(negedge clk);
    we_i = 1'b1; size_i = 2'd2; address_i = 32'h1001_0008; write_data_i = 32'hAAAA_5555;
    req_i = 1'b1;
    @(posedge clk);
    #1 req_i = 1'b0;
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort_ready", 32'(ready_o), 32'h0);
    check("abort_error", 32'(error_o), 32'h0);
    check("abort_rdata", read_data_o, 32'h0);
    last_rd_m = '0;
    @(negedge clk);
    reset = 1'b0;
    run_checked("abort_lw", 1'b0, 2'd2, 1'b0, 32'h1001_0008, 32'h0);

    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      case ($urandom_range(0, 9))
        0:       a = BASE - 32'($urandom_range(1, 16));
        1:       a = BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 64));
        default: a = BASE + 32'($urandom_range(0, 4 * DEPTH - 1));
      endcase
      run_checked("rand", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), a, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
